pipe_control_unit: RTL

- Pipelined successor to the combinational RV64 `control_unit`.
- Decodes the ID-stage opcode into the same control bundle: RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, ALUOp.
- Carries the bundle through ID/EX, EX/MEM and MEM/WB control registers.
- Generates stall (load-use / RAW) and flush (taken branch) for the 5-stage core.
- Generates forwarding selects when forwarding is compiled in.

---
 rtl/pipe_control_unit.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/pipe_control_unit.sv
// Pipelined RV64 control unit: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// stall/flush generation and optional operand forwarding (define FORWARDING_EN).
module pipe_control_unit #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [6:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_branch_taken,
    output logic                  stall,
    output logic                  flush,
    output logic                  ex_alusrc,
    output logic [1:0]            ex_aluop,
    output logic                  ex_branch,
    output logic                  ex_illegal,
    output logic                  mem_memread,
    output logic                  mem_memwrite,
    output logic                  wb_regwrite,
    output logic                  wb_memtoreg,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic                  id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic                  id_alusrc, id_branch, id_illegal;
    logic [1:0]            id_aluop;
    logic                  id_use_rs1, id_use_rs2;

    logic                  ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
    logic                  mem_regwrite, mem_memtoreg;

    logic                  hit_ex;
    logic                  raw_hazard;
    logic                  bubble;

    // Decode: an idle ID slot yields an all-zero bundle that is not illegal.
    always_comb begin
        id_regwrite = 1'b0;
        id_memread  = 1'b0;
        id_memwrite = 1'b0;
        id_memtoreg = 1'b0;
        id_alusrc   = 1'b0;
        id_branch   = 1'b0;
        id_illegal  = 1'b0;
        id_aluop    = 2'b00;
        id_use_rs1  = 1'b0;
        id_use_rs2  = 1'b0;
        if (id_valid) begin
            case (id_opcode)
                OP_R: begin
                    id_regwrite = 1'b1;
                    id_aluop    = 2'b10;
                    id_use_rs1  = 1'b1;
                    id_use_rs2  = 1'b1;
                end
                OP_I: begin
                    id_regwrite = 1'b1;
                    id_alusrc   = 1'b1;
                    id_use_rs1  = 1'b1;
                end
                OP_LD: begin
                    id_regwrite = 1'b1;
                    id_alusrc   = 1'b1;
                    id_memtoreg = 1'b1;
                    id_memread  = 1'b1;
                    id_use_rs1  = 1'b1;
                end
                OP_SD: begin
                    id_alusrc   = 1'b1;
                    id_memwrite = 1'b1;
                    id_use_rs1  = 1'b1;
                    id_use_rs2  = 1'b1;
                end
                OP_BEQ: begin
                    id_branch   = 1'b1;
                    id_aluop    = 2'b01;
                    id_use_rs1  = 1'b1;
                    id_use_rs2  = 1'b1;
                end
                default: id_illegal = 1'b1;
            endcase
        end
    end

    // Source index 0 is hardwired zero and never depends on a producer.
    always_comb begin
        hit_ex = (ex_rd != '0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    end

`ifdef FORWARDING_EN
    always_comb begin
        raw_hazard = ex_memread && hit_ex;
    end
`else
    logic hit_mem;

    always_comb begin
        hit_mem = (mem_rd != '0) &&
                  ((id_use_rs1 && (id_rs1 == mem_rd)) || (id_use_rs2 && (id_rs2 == mem_rd)));
        raw_hazard = (ex_regwrite && hit_ex) || (mem_regwrite && hit_mem);
    end
`endif

    // A taken branch squashes the ID instruction, so any stall it asked for is moot.
    always_comb begin
        flush  = ex_branch && ex_branch_taken;
        stall  = raw_hazard && !flush;
        bubble = stall || flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_aluop    <= 2'b00;
            ex_branch   <= 1'b0;
            ex_illegal  <= 1'b0;
            ex_rd       <= '0;
        end else if (bubble) begin
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_aluop    <= 2'b00;
            ex_branch   <= 1'b0;
            ex_illegal  <= 1'b0;
            ex_rd       <= '0;
        end else begin
            ex_regwrite <= id_regwrite;
            ex_memread  <= id_memread;
            ex_memwrite <= id_memwrite;
            ex_memtoreg <= id_memtoreg;
            ex_alusrc   <= id_alusrc;
            ex_aluop    <= id_aluop;
            ex_branch   <= id_branch;
            ex_illegal  <= id_illegal;
            ex_rd       <= id_valid ? id_rd : '0;
        end
    end

    // EX/MEM and MEM/WB always advance; a stall only holds the front of the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            mem_memtoreg <= 1'b0;
            mem_rd       <= '0;
            wb_regwrite  <= 1'b0;
            wb_memtoreg  <= 1'b0;
            wb_rd        <= '0;
        end else begin
            mem_regwrite <= ex_regwrite;
            mem_memread  <= ex_memread;
            mem_memwrite <= ex_memwrite;
            mem_memtoreg <= ex_memtoreg;
            mem_rd       <= ex_rd;
            wb_regwrite  <= mem_regwrite;
            wb_memtoreg  <= mem_memtoreg;
            wb_rd        <= mem_rd;
        end
    end

`ifdef FORWARDING_EN
    logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2;

    // Only sources the instruction actually reads are kept, so unused fields never forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs1 <= '0;
            ex_rs2 <= '0;
        end else if (bubble) begin
            ex_rs1 <= '0;
            ex_rs2 <= '0;
        end else begin
            ex_rs1 <= id_use_rs1 ? id_rs1 : '0;
            ex_rs2 <= id_use_rs2 ? id_rs2 : '0;
        end
    end

    // The younger producer in EX/MEM wins over MEM/WB.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs1))
            fwd_a = 2'b10;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs1))
            fwd_a = 2'b01;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs2))
            fwd_b = 2'b10;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs2))
            fwd_b = 2'b01;
    end
`else
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

endmodule
